imem_loader: RTL and testbench

- Serial boot loader: the write-side counterpart of the instruction ROM.
- Accepts a byte stream from the UART receiver and parses a framed program image.
- Assembles little-endian 32-bit words and writes them into a writable instruction memory.
- Holds the CPU in reset while a load is in progress and reports done or error.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 21 ++
 rtl/loader_word_packer.sv | 54 +++++
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the serial instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         COUNT_W       = 16;
    localparam int         CSUM_W        = 8;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, memory write port and status out
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output rx_valid, rx_data,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

    modport slave (
        input  rx_valid, rx_data,
        output mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - packs bytes into little-endian words and issues memory writes
module loader_word_packer #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                last_lane,
    output logic [ADDR_WIDTH:0] word_idx,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata
);

    logic [1:0]  byte_idx;
    // Earlier bytes shift down so the oldest ends up in bits [7:0] of the word.
    logic [23:0] lanes;

    assign last_lane = byte_valid && (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            lanes     <= '0;
            word_idx  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start || abort) begin
                byte_idx <= '0;
                lanes    <= '0;
                word_idx <= '0;
            end else if (byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= {byte_data, lanes};
                    mem_addr  <= BASE_ADDR + (32'(word_idx) << 2);
                    word_idx  <= word_idx + 1'b1;
                    lanes     <= '0;
                end else begin
                    lanes <= {byte_data, lanes[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - frame parser, checksum and timeout for the serial boot loader
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state;
    logic [COUNT_W-1:0]  count;
    logic [CSUM_W-1:0]   csum;
    logic [TO_W-1:0]     idle_cnt;
    logic                cpu_hold;
    logic                done;
    logic                err;

    logic                pk_start;
    logic                pk_byte;
    logic                pk_last;
    logic [ADDR_WIDTH:0] word_idx;
    logic                timeout;
    logic                last_word;
    logic [COUNT_W-1:0]  new_count;

    assign new_count = {bus.rx_data, count[7:0]};
    assign pk_start  = (state == LEN1) && bus.rx_valid;
    assign pk_byte   = (state == DATA) && bus.rx_valid;
    assign timeout   = (state != IDLE) && !bus.rx_valid
                       && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign last_word = pk_last && ((32'(word_idx) + 32'd1) == 32'(count));

    loader_word_packer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (pk_start),
        .abort      (timeout),
        .byte_valid (pk_byte),
        .byte_data  (bus.rx_data),
        .last_lane  (pk_last),
        .word_idx   (word_idx),
        .mem_we     (bus.mem_we),
        .mem_addr   (bus.mem_addr),
        .mem_wdata  (bus.mem_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            csum     <= '0;
            idle_cnt <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE || bus.rx_valid) idle_cnt <= '0;
            else                               idle_cnt <= idle_cnt + 1'b1;

            if (timeout) begin
                state    <= IDLE;
                err      <= 1'b1;
                done     <= 1'b0;
                cpu_hold <= 1'b0;
            end else if (bus.rx_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.rx_data == MAGIC) begin
                            state    <= LEN0;
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            csum     <= '0;
                        end
                    end
                    LEN0: begin
                        count[7:0] <= bus.rx_data;
                        state      <= LEN1;
                    end
                    LEN1: begin
                        count[15:8] <= bus.rx_data;
                        // Oversized images are refused before any word is written.
                        if (32'(new_count) > (32'd1 << ADDR_WIDTH)) begin
                            err      <= 1'b1;
                            state    <= IDLE;
                            cpu_hold <= 1'b0;
                        end else if (new_count == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        csum <= csum + bus.rx_data;
                        if (last_word) state <= CSUM;
                    end
                    CSUM: begin
                        if (bus.rx_data == csum) done <= 1'b1;
                        else                     err  <= 1'b1;
                        state    <= IDLE;
                        cpu_hold <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cpu_hold = cpu_hold;
    assign bus.done     = done;
    assign bus.err      = err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          TO   = 100;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst_n;
    imem_loader_if bus ();

    imem_loader #(
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (BASE),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    logic [7:0]  frame_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, w.a);
                check("wr_data", bus.mem_wdata, w.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic we_exp, input logic hold_exp);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("we_timing", 32'(bus.mem_we), 32'(we_exp));
        check("cpu_hold", 32'(bus.cpu_hold), 32'(hold_exp));
        check("flags_exclusive", 32'(bus.done & bus.err), 32'd0);
    endtask

    task automatic build_frame(input int cnt, input bit bad);
        int s;
        s = 0;
        frame_q = {};
        frame_q.push_back(8'hA5);
        frame_q.push_back(cnt[7:0]);
        frame_q.push_back(cnt[15:8]);
        for (int i = 0; i < 4 * cnt; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
            frame_q.push_back(b);
            s += int'(b);
        end
        frame_q.push_back(8'(s) ^ (bad ? 8'h01 : 8'h00));
    endtask

    // Reference: frame-level rules applied to the whole byte list at once.
    task automatic do_frame(input int max_gap);
        int         cnt;
        bit         ovf;
        int         s;
        int         last;
        bit         exp_done;
        cnt  = int'({frame_q[2], frame_q[1]});
        ovf  = cnt > (1 << AW);
        last = frame_q.size() - 1;
        s    = 0;
        if (!ovf) begin
            for (int w = 0; w < cnt; w++) begin
                wr_t e;
                e.a = BASE + 32'(4 * w);
                e.d = {frame_q[3+4*w+3], frame_q[3+4*w+2], frame_q[3+4*w+1], frame_q[3+4*w]};
                exp_q.push_back(e);
            end
            for (int i = 3; i < 3 + 4 * cnt; i++) s += int'(frame_q[i]);
        end
        exp_done = !ovf && (frame_q[last] == 8'(s));
        for (int i = 0; i <= last; i++) begin
            logic we_exp;
            we_exp = !ovf && i >= 3 && i < 3 + 4 * cnt && ((i - 3) % 4 == 3);
            send_byte(frame_q[i], we_exp, i != last);
            if (i == last) begin
                check("done", 32'(bus.done), 32'(exp_done));
                check("err", 32'(bus.err), 32'(!exp_done));
            end
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(bus.mem_we),   32'd0);
        check({tag, "_addr"},  bus.mem_addr,      32'd0);
        check({tag, "_wdata"}, bus.mem_wdata,     32'd0);
        check({tag, "_hold"},  32'(bus.cpu_hold), 32'd0);
        check({tag, "_done"},  32'(bus.done),     32'd0);
        check({tag, "_err"},   32'(bus.err),      32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        do_frame(0);

        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        do_frame(1);

        frame_q = '{8'hA5, 8'h01, 8'h10};
        do_frame(0);

        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        do_frame(0);
        send_byte(8'h55, 1'b0, 1'b0);
        check("garbage_done", 32'(bus.done), 32'd1);
        check("garbage_err", 32'(bus.err), 32'd0);

        // Stall mid-word: the timeout must fire on exactly the 100th idle edge.
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b0, 1'b1);
        repeat (TO - 1) @(negedge clk);
        check("to_early_err", 32'(bus.err), 32'd0);
        check("to_early_hold", 32'(bus.cpu_hold), 32'd1);
        @(negedge clk);
        check("to_err", 32'(bus.err), 32'd1);
        check("to_hold", 32'(bus.cpu_hold), 32'd0);
        build_frame(2, 1'b0);
        do_frame(2);

        // Asynchronous reset mid-DATA after one word has already been written.
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_q.push_back('{a: BASE, d: 32'h4433_2211});
        foreach (frame_q[i]) send_byte(frame_q[i], i == 6, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_frame(3, 1'b0);
        do_frame(0);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] g;
                logic       d0;
                logic       e0;
                g  = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                d0 = bus.done;
                e0 = bus.err;
                send_byte(g, 1'b0, 1'b0);
                check("idle_done_kept", 32'(bus.done), 32'(d0));
                check("idle_err_kept", 32'(bus.err), 32'(e0));
            end
            build_frame($urandom_range(0, 6), $urandom_range(0, 2) == 0);
            do_frame(3);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
